// File: rtl/id_ex_operand_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_operand_stage_pkg
// Purpose  : Shared widths, the execute-control bundle type and register
//            constants for the decode/execute operand stage.
// Revision : 1.0 - initial release
// ============================================================================
package id_ex_operand_stage_pkg;

    localparam int REG_IDX_W = 5;
    localparam int DATA_W    = 32;
    localparam int CTRL_W    = 16;

    // Opaque control bundle handed to execute without interpretation
    typedef logic [CTRL_W-1:0] ctrl_t;

    // Architectural zero register: always reads as zero, never a hazard source
    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

    // A source only participates in forwarding/hazards if it is read and nonzero
    function automatic logic src_live(input logic [REG_IDX_W-1:0] idx, input logic used);
        return used && (idx != REG_ZERO);
    endfunction

endpackage : id_ex_operand_stage_pkg
`default_nettype wire

// File: rtl/id_ex_operand_stage_fwd.sv
`default_nettype none
// ============================================================================
// Module   : operand_fwd
// Purpose  : Resolves one source operand (zero reg, MEM forward, WB forward,
//            register file) and flags when that operand is not yet available.
// Revision : 1.0 - initial release
// ============================================================================
module operand_fwd
    import id_ex_operand_stage_pkg::*;
#(
    parameter int DATA_W = id_ex_operand_stage_pkg::DATA_W
) (
    input  logic [REG_IDX_W-1:0] src_idx_i,
    input  logic                 src_used_i,
    input  logic [DATA_W-1:0]    rf_rdata_i,
    input  logic                 ex_valid_i,
    input  logic                 ex_reg_write_i,
    input  logic [REG_IDX_W-1:0] ex_dest_i,
    input  logic                 mem_reg_write_i,
    input  logic                 mem_mem_read_i,
    input  logic [REG_IDX_W-1:0] mem_waddr_i,
    input  logic [DATA_W-1:0]    mem_wdata_i,
    input  logic                 wb_reg_write_i,
    input  logic [REG_IDX_W-1:0] wb_waddr_i,
    input  logic [DATA_W-1:0]    wb_wdata_i,
    output logic [DATA_W-1:0]    value_o,
    output logic                 hazard_o
);

    logic w_is_zero;
    logic w_mem_hit;
    logic w_wb_hit;
    logic w_live;

    assign w_is_zero = (src_idx_i == REG_ZERO);
    // A load in MEM has no data yet, so it never forwards; it stalls instead
    assign w_mem_hit = mem_reg_write_i && !mem_mem_read_i && (mem_waddr_i == src_idx_i);
    // WB write lands in the register file only at the edge, so bypass it now
    assign w_wb_hit  = wb_reg_write_i && (wb_waddr_i == src_idx_i);
    assign w_live    = src_live(src_idx_i, src_used_i);

    // Priority select: zero register, youngest producer (MEM), then WB, then RF
    always_comb begin
        value_o = rf_rdata_i;
        if (w_is_zero) begin
            value_o = '0;
        end else if (w_mem_hit) begin
            value_o = mem_wdata_i;
        end else if (w_wb_hit) begin
            value_o = wb_wdata_i;
        end
    end

    // Producer still in EX (any kind) or a load in MEM: value not available yet
    always_comb begin
        hazard_o = 1'b0;
        if (w_live) begin
            hazard_o = (ex_valid_i && ex_reg_write_i && (ex_dest_i == src_idx_i)) ||
                       (mem_reg_write_i && mem_mem_read_i && (mem_waddr_i == src_idx_i));
        end
    end

endmodule : operand_fwd
`default_nettype wire

// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_operand_stage
// Purpose  : Drives register-file reads, forwards MEM/WB results, stalls
//            decode on unresolved RAW hazards and holds the ID/EX register
//            with valid/ready handshakes and flush.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_operand_stage
    import id_ex_operand_stage_pkg::*;
#(
    parameter int CTRL_W = id_ex_operand_stage_pkg::CTRL_W,
    parameter int DATA_W = id_ex_operand_stage_pkg::DATA_W
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 id_valid,
    output logic                 id_ready,
    input  logic [REG_IDX_W-1:0] id_rs,
    input  logic [REG_IDX_W-1:0] id_rt,
    input  logic                 id_rs_used,
    input  logic                 id_rt_used,
    input  logic [REG_IDX_W-1:0] id_dest,
    input  logic                 id_reg_write,
    input  logic                 id_mem_read,
    input  logic [DATA_W-1:0]    id_imm,
    input  logic [CTRL_W-1:0]    id_ctrl,
    output logic [REG_IDX_W-1:0] rf_raddr1,
    output logic [REG_IDX_W-1:0] rf_raddr2,
    input  logic [DATA_W-1:0]    rf_rdata1,
    input  logic [DATA_W-1:0]    rf_rdata2,
    input  logic                 mem_reg_write,
    input  logic                 mem_mem_read,
    input  logic [REG_IDX_W-1:0] mem_waddr,
    input  logic [DATA_W-1:0]    mem_wdata,
    input  logic                 wb_reg_write,
    input  logic [REG_IDX_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0]    wb_wdata,
    input  logic                 ex_ready,
    input  logic                 flush,
    output logic                 ex_valid,
    output logic [DATA_W-1:0]    ex_rs_val,
    output logic [DATA_W-1:0]    ex_rt_val,
    output logic [DATA_W-1:0]    ex_imm,
    output logic [REG_IDX_W-1:0] ex_dest,
    output logic                 ex_reg_write,
    output logic                 ex_mem_read,
    output logic [CTRL_W-1:0]    ex_ctrl
);

    logic                 ex_valid_q;
    logic [DATA_W-1:0]    ex_rs_val_q,  ex_rs_val_d;
    logic [DATA_W-1:0]    ex_rt_val_q,  ex_rt_val_d;
    logic [DATA_W-1:0]    ex_imm_q;
    logic [REG_IDX_W-1:0] ex_dest_q;
    logic                 ex_reg_write_q;
    logic                 ex_mem_read_q;
    logic [CTRL_W-1:0]    ex_ctrl_q;
    logic                 ex_valid_d;

    logic w_haz_rs;
    logic w_haz_rt;
    logic w_hazard;
    logic w_advance;

    assign rf_raddr1 = id_rs;
    assign rf_raddr2 = id_rt;

    operand_fwd #(.DATA_W(DATA_W)) u_fwd_rs (
        .src_idx_i       (id_rs),
        .src_used_i      (id_rs_used),
        .rf_rdata_i      (rf_rdata1),
        .ex_valid_i      (ex_valid_q),
        .ex_reg_write_i  (ex_reg_write_q),
        .ex_dest_i       (ex_dest_q),
        .mem_reg_write_i (mem_reg_write),
        .mem_mem_read_i  (mem_mem_read),
        .mem_waddr_i     (mem_waddr),
        .mem_wdata_i     (mem_wdata),
        .wb_reg_write_i  (wb_reg_write),
        .wb_waddr_i      (wb_waddr),
        .wb_wdata_i      (wb_wdata),
        .value_o         (ex_rs_val_d),
        .hazard_o        (w_haz_rs)
    );

    operand_fwd #(.DATA_W(DATA_W)) u_fwd_rt (
        .src_idx_i       (id_rt),
        .src_used_i      (id_rt_used),
        .rf_rdata_i      (rf_rdata2),
        .ex_valid_i      (ex_valid_q),
        .ex_reg_write_i  (ex_reg_write_q),
        .ex_dest_i       (ex_dest_q),
        .mem_reg_write_i (mem_reg_write),
        .mem_mem_read_i  (mem_mem_read),
        .mem_waddr_i     (mem_waddr),
        .mem_wdata_i     (mem_wdata),
        .wb_reg_write_i  (wb_reg_write),
        .wb_waddr_i      (wb_waddr),
        .wb_wdata_i      (wb_wdata),
        .value_o         (ex_rt_val_d),
        .hazard_o        (w_haz_rt)
    );

    assign w_hazard  = w_haz_rs || w_haz_rt;
    // The ID/EX slot can take something new when it is empty or being drained
    assign w_advance = !ex_valid_q || ex_ready;
    assign id_ready  = w_advance && !w_hazard && !flush;

    // Next valid: flush kills, a hazard inserts a bubble, otherwise follow decode
    always_comb begin
        ex_valid_d = ex_valid_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (w_advance) begin
            ex_valid_d = id_valid && !w_hazard;
        end
    end

    // Valid bit: cleared asynchronously so nothing in flight survives reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_valid_q <= 1'b0;
        end else begin
            ex_valid_q <= ex_valid_d;
        end
    end

    // Payload loads on every advance; it is qualified downstream by ex_valid
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_rs_val_q    <= '0;
            ex_rt_val_q    <= '0;
            ex_imm_q       <= '0;
            ex_dest_q      <= '0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_ctrl_q      <= '0;
        end else if (w_advance && !flush) begin
            ex_rs_val_q    <= ex_rs_val_d;
            ex_rt_val_q    <= ex_rt_val_d;
            ex_imm_q       <= id_imm;
            ex_dest_q      <= id_dest;
            ex_reg_write_q <= id_reg_write;
            ex_mem_read_q  <= id_mem_read;
            ex_ctrl_q      <= id_ctrl;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_rs_val    = ex_rs_val_q;
    assign ex_rt_val    = ex_rt_val_q;
    assign ex_imm       = ex_imm_q;
    assign ex_dest      = ex_dest_q;
    assign ex_reg_write = ex_reg_write_q;
    assign ex_mem_read  = ex_mem_read_q;
    assign ex_ctrl      = ex_ctrl_q;

endmodule : id_ex_operand_stage
`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_operand_stage
// Purpose  : Self-checking bench: directed scenarios with literal expectations
//            followed by randomized traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        id_valid, id_ready;
    logic [4:0]  id_rs, id_rt, id_dest;
    logic        id_rs_used, id_rt_used, id_reg_write, id_mem_read;
    logic [31:0] id_imm;
    logic [15:0] id_ctrl;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        mem_reg_write, mem_mem_read;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        wb_reg_write;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        ex_ready, flush;
    logic        ex_valid;
    logic [31:0] ex_rs_val, ex_rt_val, ex_imm;
    logic [4:0]  ex_dest;
    logic        ex_reg_write, ex_mem_read;
    logic [15:0] ex_ctrl;

    int checks   = 0;
    int failures = 0;

    id_ex_operand_stage #(.CTRL_W(16), .DATA_W(32)) dut (
        .clk(clk), .rstn(rstn),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_dest(id_dest), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_imm(id_imm), .id_ctrl(id_ctrl),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .wb_reg_write(wb_reg_write), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .ex_ready(ex_ready), .flush(flush),
        .ex_valid(ex_valid), .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val),
        .ex_imm(ex_imm), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_ctrl(ex_ctrl)
    );

    always #5 clk = ~clk;

    // ---------------- register file (written by the WB port) ----------------
    logic [31:0] regs [32];
    assign rf_rdata1 = regs[rf_raddr1];
    assign rf_rdata2 = regs[rf_raddr2];

    // Register-file contents: known preload on reset, WB commits at the edge
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 32; i++) regs[i] <= (i == 5) ? 32'h11 : 32'h1000_0000 + i;
        end else if (wb_reg_write) begin
            regs[wb_waddr] <= wb_wdata;
        end
    end

    // ---------------- behavioural model of the ID/EX slot ----------------
    typedef struct {
        logic        valid;
        logic [31:0] rs_val, rt_val, imm;
        logic [4:0]  dest;
        logic        rw, mr;
        logic [15:0] ctrl;
    } slot_t;
    slot_t m;

    // What value a source would read right now, from the architectural rules
    function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 0) return 32'h0;
        if (mem_reg_write && !mem_mem_read && mem_waddr == idx) return mem_wdata;
        if (wb_reg_write && wb_waddr == idx) return wb_wdata;
        return rf;
    endfunction

    // Operand not yet produced: its producer is in the EX slot, or a load in MEM
    function automatic logic pending(input logic [4:0] idx, input logic used);
        if (!used || idx == 0) return 1'b0;
        return (m.valid && m.rw && m.dest == idx) ||
               (mem_reg_write && mem_mem_read && mem_waddr == idx);
    endfunction

    function automatic logic slot_free();
        return !m.valid || ex_ready;
    endfunction

    function automatic logic exp_ready();
        return slot_free() && !pending(id_rs, id_rs_used) && !pending(id_rt, id_rt_used) && !flush;
    endfunction

    // Model slot update at each edge; reset empties it immediately
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m <= '{valid: 1'b0, rs_val: 0, rt_val: 0, imm: 0, dest: 0, rw: 0, mr: 0, ctrl: 0};
        end else if (flush) begin
            m.valid <= 1'b0;
        end else if (slot_free()) begin
            if (pending(id_rs, id_rs_used) || pending(id_rt, id_rt_used)) begin
                m.valid <= 1'b0;
            end else begin
                m.valid  <= id_valid;
                m.rs_val <= operand(id_rs, rf_rdata1);
                m.rt_val <= operand(id_rt, rf_rdata2);
                m.imm    <= id_imm;
                m.dest   <= id_dest;
                m.rw     <= id_reg_write;
                m.mr     <= id_mem_read;
                m.ctrl   <= id_ctrl;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Every cycle: compare handshake, addresses and the slot against the model
    always @(negedge clk) begin
        chk("m_id_ready", id_ready, exp_ready());
        chk("m_raddr1", rf_raddr1, id_rs);
        chk("m_raddr2", rf_raddr2, id_rt);
        chk("m_ex_valid", ex_valid, m.valid);
        if (m.valid || !rstn) begin
            chk("m_rs_val", ex_rs_val, m.rs_val);
            chk("m_rt_val", ex_rt_val, m.rt_val);
            chk("m_imm", ex_imm, m.imm);
            chk("m_dest", ex_dest, m.dest);
            chk("m_rw_mr", {ex_reg_write, ex_mem_read}, {m.rw, m.mr});
            chk("m_ctrl", ex_ctrl, m.ctrl);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
        id_dest = 0; id_reg_write = 0; id_mem_read = 0; id_imm = 0; id_ctrl = 0;
        mem_reg_write = 0; mem_mem_read = 0; mem_waddr = 0; mem_wdata = 0;
        wb_reg_write = 0; wb_waddr = 0; wb_wdata = 0;
        ex_ready = 1; flush = 0;
    endtask

    initial begin
        idle();
        rstn = 0;
        id_valid = 1; id_imm = $urandom; id_ctrl = 16'hFFFF; id_reg_write = 1; id_dest = 5'd7;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_ex_imm", ex_imm, 0);
        chk("rst_ex_ctrl", ex_ctrl, 0);
        chk("rst_ex_rest", {ex_rs_val, ex_rt_val, ex_dest, ex_reg_write, ex_mem_read}, 0);
        step(); rstn = 1; idle();
        @(negedge clk);
        chk("rst_id_ready", id_ready, 1);

        // WB forward beats stale register-file data
        step(); id_valid = 1; id_rs = 5; id_rs_used = 1;
        wb_reg_write = 1; wb_waddr = 5; wb_wdata = 32'hAAAA_0000;
        step(); idle();
        @(negedge clk);
        chk("wb_fwd_valid", ex_valid, 1);
        chk("wb_fwd_val", ex_rs_val, 32'hAAAA_0000);

        // MEM forward wins over WB
        step(); id_valid = 1; id_rs = 5; id_rs_used = 1;
        mem_reg_write = 1; mem_waddr = 5; mem_wdata = 32'h0000_BBBB;
        wb_reg_write = 1; wb_waddr = 5; wb_wdata = 32'hCCCC_0000;
        step(); idle();
        @(negedge clk);
        chk("mem_over_wb", ex_rs_val, 32'h0000_BBBB);

        // Zero register ignores a matching MEM write
        step(); id_valid = 1; id_rs = 0; id_rs_used = 1;
        mem_reg_write = 1; mem_waddr = 0; mem_wdata = 32'h0000_FFFF;
        step(); idle();
        @(negedge clk);
        chk("zero_reg", ex_rs_val, 0);

        // Load-use: two bubbles, then operand comes from WB
        step(); id_valid = 1; id_dest = 8; id_reg_write = 1; id_mem_read = 1;
        step(); idle(); id_valid = 1; id_rt = 8; id_rt_used = 1; id_imm = 32'h77;
        @(negedge clk);
        chk("lu_ready_c1", id_ready, 0);
        chk("lu_load_in_ex", ex_valid, 1);
        step(); mem_reg_write = 1; mem_mem_read = 1; mem_waddr = 8;
        @(negedge clk);
        chk("lu_ready_c2", id_ready, 0);
        chk("lu_bubble1", ex_valid, 0);
        step(); mem_reg_write = 0; mem_mem_read = 0; mem_waddr = 0;
        wb_reg_write = 1; wb_waddr = 8; wb_wdata = 32'h1234;
        @(negedge clk);
        chk("lu_ready_c3", id_ready, 1);
        chk("lu_bubble2", ex_valid, 0);
        step(); idle();
        @(negedge clk);
        chk("lu_valid", ex_valid, 1);
        chk("lu_rt_val", ex_rt_val, 32'h1234);
        chk("lu_imm", ex_imm, 32'h77);

        // Backpressure: contents hold for 3 cycles, then the waiting op loads
        step(); id_valid = 1; id_imm = 32'hA1; id_dest = 3; id_reg_write = 1; id_ctrl = 16'h5A5A;
        step(); idle(); ex_ready = 0;
        id_valid = 1; id_imm = 32'hB2; id_rs = 9; id_rs_used = 1; id_dest = 4; id_ctrl = 16'hC3C3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_ready", id_ready, 0);
            chk("bp_valid", ex_valid, 1);
            chk("bp_imm", ex_imm, 32'hA1);
            chk("bp_ctrl", ex_ctrl, 16'h5A5A);
            step();
        end
        ex_ready = 1;
        @(negedge clk);
        chk("bp_release_ready", id_ready, 1);
        step(); idle();
        @(negedge clk);
        chk("bp_new_imm", ex_imm, 32'hB2);
        chk("bp_new_ctrl", ex_ctrl, 16'hC3C3);

        // Flush while stalled downstream
        step(); idle(); id_valid = 1; id_imm = 32'hD4;
        step(); idle(); ex_ready = 0; flush = 1; id_valid = 1;
        @(negedge clk);
        chk("fl_pre_valid", ex_valid, 1);
        chk("fl_ready", id_ready, 0);
        step(); flush = 0; id_valid = 0;
        @(negedge clk);
        chk("fl_valid", ex_valid, 0);

        // Reset mid-stall clears the slot without waiting for a clock
        step(); idle(); id_valid = 1; id_imm = 32'hE5;
        step(); idle(); ex_ready = 0;
        @(negedge clk);
        chk("ar_pre_valid", ex_valid, 1);
        #2 rstn = 0;
        #1 chk("ar_async_clear", ex_valid, 0);
        step(); step(); rstn = 1; idle();
        @(negedge clk);
        chk("ar_ready_after", id_ready, 1);

        // Randomized traffic, checked every cycle by the model
        for (int n = 0; n < 4000; n++) begin
            step();
            id_valid      = ($urandom_range(0, 3) != 0);
            id_rs         = 5'($urandom_range(0, 7));
            id_rt         = 5'($urandom_range(0, 7));
            id_rs_used    = $urandom_range(0, 1);
            id_rt_used    = $urandom_range(0, 1);
            id_dest       = 5'($urandom_range(0, 7));
            id_reg_write  = $urandom_range(0, 1);
            id_mem_read   = ($urandom_range(0, 3) == 0);
            id_imm        = $urandom;
            id_ctrl       = 16'($urandom);
            mem_reg_write = $urandom_range(0, 1);
            mem_mem_read  = ($urandom_range(0, 2) == 0);
            mem_waddr     = 5'($urandom_range(0, 7));
            mem_wdata     = $urandom;
            wb_reg_write  = $urandom_range(0, 1);
            wb_waddr      = 5'($urandom_range(0, 7));
            wb_wdata      = $urandom;
            ex_ready      = ($urandom_range(0, 9) < 7);
            flush         = ($urandom_range(0, 15) == 0);
        end
        step(); idle();
        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_id_ex_operand_stage
`default_nettype wire

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- Decode-side operand stage that drives the register-file read addresses and takes the returned read data.
- Resolves RAW hazards by forwarding from the MEM and WB stages, and stalls decode when an operand is not yet available.
- Holds the ID/EX pipeline register that feeds the execute stage, with a valid/ready handshake on both sides and a flush input for redirects.

Parameters:
- CTRL_W, 16, width of the opaque execute-control bundle carried through unchanged.
- DATA_W, 32, operand/data width.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- id_valid  in  1  decode holds a valid instruction.
- id_ready  out  1  this stage accepts the decode instruction this cycle.
- id_rs, id_rt  in  5  source register indices.
- id_rs_used, id_rt_used  in  1  source actually read by the instruction.
- id_dest  in  5  destination index.
- id_reg_write  in  1  instruction writes id_dest.
- id_mem_read  in  1  instruction is a load.
- id_imm  in  DATA_W  extended immediate.
- id_ctrl  in  CTRL_W  execute control bundle.
- rf_raddr1, rf_raddr2  out  5  register-file read addresses; equal to id_rs and id_rt, combinational.
- rf_rdata1, rf_rdata2  in  DATA_W  register-file read data, combinational.
- mem_reg_write, mem_mem_read  in  1  MEM-stage instruction writes a register / is a load.
- mem_waddr  in  5  MEM-stage destination index.
- mem_wdata  in  DATA_W  MEM-stage ALU result.
- wb_reg_write  in  1  WB-stage write enable; the same signal drives the register-file write.
- wb_waddr  in  5  WB-stage destination index.
- wb_wdata  in  DATA_W  WB-stage write data.
- ex_ready  in  1  execute stage accepts the current ID/EX contents.
- flush  in  1  kill the instruction in ID and the ID/EX contents.
- ex_valid  out  1  ID/EX register holds a valid instruction.
- ex_rs_val, ex_rt_val  out  DATA_W  resolved operands.
- ex_imm  out  DATA_W  registered id_imm.
- ex_dest  out  5  registered id_dest.
- ex_reg_write, ex_mem_read  out  1  registered id_reg_write / id_mem_read.
- ex_ctrl  out  CTRL_W  registered id_ctrl.

Behaviour:
- Reset: all ex_* outputs are 0 while rstn is low. id_ready is driven combinationally from registered state, so it reads 1 after reset.
- Operand resolution (per source, combinational, priority order):
  - Index 0 gives 0.
  - Else MEM match (mem_reg_write, mem_waddr equal to the index, mem_mem_read=0) gives mem_wdata.
  - Else WB match gives wb_wdata. The register file commits at the clock edge, so a same-cycle read returns stale data without this path.
  - Else rf_rdata.
- Hazards apply only to a used source with a nonzero index:
  - haz_ex: ex_valid, ex_reg_write and ex_dest equal to the source index.
  - haz_mem: mem_reg_write, mem_mem_read and mem_waddr equal to the source index.
  - hazard = haz_ex OR haz_mem.
- Resulting stalls: ALU→dependent costs 1 bubble cycle; load→use costs 2 bubble cycles.
- Handshake:
  - advance = NOT ex_valid OR ex_ready.
  - id_ready = advance AND NOT hazard AND NOT flush.
  - The ID/EX register is updated only when advance=1. When advance=0 every ex_* output holds.
- Clock-edge update priority:
  - flush=1: ex_valid becomes 0 and id_ready=0 that cycle. Decode discards its own instruction.
  - Else advance=1 AND hazard=1: bubble inserted, ex_valid becomes 0.
  - Else advance=1: ex_valid becomes id_valid, and all fields load from id_* and the resolved operands.
  - Else: hold.
- Payload fields may load when id_valid=0, but ex_valid must be 0 in that case.
- Load latency: 1 cycle from id_valid AND id_ready to ex_valid.
- Operands are sampled only at load time. No forwarding is applied to held ID/EX contents; all hazards are covered by the stall rules above.
- Reset asserted mid-stall clears ex_valid immediately (asynchronously). No pending state survives reset.

Decomposition:
- Shared cpu package holds:
  - REG_IDX_W=5 and DATA_W.
  - CTRL_W and the ctrl bundle typedef.
  - Constant REG_ZERO=5'd0.
- One sub-module, operand_fwd: source index, rf data, MEM/WB ports in → resolved value and hazard bit out. Instantiated twice, once per source.

Test Plan:
- Reset: rstn=0 with arbitrary inputs → ex_valid=0 and all ex_* =0. After release, id_ready=1 with no hazard inputs.
- WB forward: wb_reg_write=1, wb_waddr=5, wb_wdata=0xAAAA0000, rf_rdata1=0x11 for id_rs=5 → next cycle ex_rs_val=0xAAAA0000. MEM write to 5 with 0xBBBB at the same time → 0xBBBB wins.
- Zero register: id_rs=0, mem_waddr=0, mem_reg_write=1, mem_wdata=0xFFFF → ex_rs_val=0.
- Load-use: load with dest 8 in EX, next instruction uses rt=8 → id_ready=0 for 2 cycles and ex_valid=0 for those 2 cycles. Third cycle takes rt from WB (wb_wdata=0x1234) → ex_rt_val=0x1234.
- Backpressure: ex_valid=1, ex_ready=0 for 3 cycles with new id_* → all ex_* hold and id_ready=0. ex_ready=1 → new instruction loads next edge.
- Flush: flush=1 while ex_valid=1 and ex_ready=0 → ex_valid=0 next edge and id_ready=0 that cycle.
